// File: rtl/arb_dp_burst_sched.sv
// Burst scheduler: dynamic-priority plus age arbitration, then burst ownership
// of a shared resource until the final acknowledged beat.
module arb_dp_burst_sched #(
    parameter int n           = 4,
    parameter int index_width = 2,
    parameter int prior_width = 2,
    parameter int age_width   = 4,
    parameter int len_width   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [n-1:0]                request,
    input  logic [n*prior_width-1:0]    prior,
    input  logic [n-1:0]                mask,
    input  logic [n*len_width-1:0]      burst_len,
    input  logic                        beat,
    output logic                        granted,
    output logic [n-1:0]                grant,
    output logic [index_width-1:0]      grant_index,
    output logic                        last,
    output logic [n-1:0]                age_sat
);

    localparam int uw = ((prior_width > age_width) ? prior_width : age_width) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [index_width-1:0] owner_q, owner_d;
    logic [n-1:0]           grant_q, grant_d;
    logic [len_width-1:0]   count_q, count_d;
    logic [age_width-1:0]   age_q [n];
    logic [age_width-1:0]   age_d [n];
    logic [n-1:0]           age_sat_q;

    logic [prior_width-1:0] p_inv [n];
    logic [len_width-1:0]   bl_arr [n];
    logic [uw-1:0]          urg [n];
    logic [n-1:0]           eligible;
    logic                   any_eligible;
    logic [index_width-1:0] win_idx;
    logic [uw-1:0]          best_urg;
    logic                   win_found;
    logic                   do_arb;

    assign eligible     = request & ~mask;
    assign any_eligible = |eligible;

    // Inverted priority gives 2^w-1 - prior, so 0 is the most urgent field.
    always_comb begin
        for (int i = 0; i < n; i++) begin
            p_inv[i]  = ~prior[i*prior_width +: prior_width];
            bl_arr[i] = burst_len[i*len_width +: len_width];
            urg[i]    = uw'(p_inv[i]) + uw'(age_q[i]);
        end
    end

    // Strict greater-than while scanning upward keeps ties at the lowest index.
    always_comb begin
        win_idx   = '0;
        best_urg  = '0;
        win_found = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (eligible[i] && (!win_found || urg[i] > best_urg)) begin
                win_found = 1'b1;
                best_urg  = urg[i];
                win_idx   = index_width'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        count_d = count_q;
        do_arb  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && any_eligible) do_arb = 1'b1;
            end
            BUSY: begin
                if (!request[owner_q]) begin
                    state_d = IDLE;
                    owner_d = '0;
                    grant_d = '0;
                    count_d = '0;
                end else if (beat) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (enable && any_eligible) begin
                        do_arb = 1'b1;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_arb) begin
            state_d          = BUSY;
            owner_d          = win_idx;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            count_d          = bl_arr[win_idx];
        end
    end

    // The owner's age is frozen for the whole burst, including an abort cycle.
    always_comb begin
        for (int i = 0; i < n; i++) begin
            age_d[i] = age_q[i];
            if (do_arb && win_idx == index_width'(i)) begin
                age_d[i] = '0;
            end else if (eligible[i] && &age_q[i] == 1'b0 &&
                         !(state_q == BUSY && owner_q == index_width'(i))) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            grant_q   <= '0;
            count_q   <= '0;
            age_sat_q <= '0;
            for (int i = 0; i < n; i++) age_q[i] <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            count_q <= count_d;
            for (int i = 0; i < n; i++) begin
                age_q[i]     <= age_d[i];
                age_sat_q[i] <= &age_d[i];
            end
        end
    end

    assign granted     = (state_q == BUSY);
    assign grant       = grant_q;
    assign grant_index = owner_q;
    assign last        = (state_q == BUSY) && (count_q == '0);
    assign age_sat     = age_sat_q;

endmodule

// File: tb/tb_arb_dp_burst_sched.sv
// Bench for arb_dp_burst_sched: directed vector table, corner sequences,
// and random traffic against an integer reference model.
module tb_arb_dp_burst_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  request = '0;
    logic [7:0]  prior = '0;
    logic [3:0]  mask = '0;
    logic [15:0] burst_len = '0;
    logic        beat = 1'b0;
    logic        granted;
    logic [3:0]  grant;
    logic [1:0]  grant_index;
    logic        last;
    logic [3:0]  age_sat;

    int n_checks = 0;
    int n_pass = 0;

    int m_owner = -1;
    int m_rem = 0;
    int m_age [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    arb_dp_burst_sched #(
        .n(4), .index_width(2), .prior_width(2), .age_width(4), .len_width(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .request(request),
        .prior(prior), .mask(mask), .burst_len(burst_len), .beat(beat),
        .granted(granted), .grant(grant), .grant_index(grant_index),
        .last(last), .age_sat(age_sat)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [3:0]  req;
        logic [3:0]  msk;
        logic [7:0]  pri;
        logic [15:0] bl;
        logic        bt;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] m,
                                logic [7:0] p, logic [15:0] b, logic t,
                                logic g, logic [3:0] gr, logic [1:0] ix,
                                logic l, logic [3:0] s);
        vec_t v;
        v.rst_n = r; v.en = e; v.req = q; v.msk = m;
        v.pri = p; v.bl = b; v.bt = t;
        v.exp = {g, gr, ix, l, s};
        return v;
    endfunction

    function automatic logic [11:0] dut_vec();
        return {granted, grant, grant_index, last, age_sat};
    endfunction

    function automatic logic [11:0] model_vec();
        logic [3:0] g;
        logic [3:0] s;
        logic [1:0] ix;
        logic       act;
        g = '0;
        ix = '0;
        act = (m_owner >= 0);
        if (act) begin
            g[m_owner] = 1'b1;
            ix = m_owner[1:0];
        end
        for (int i = 0; i < 4; i++) s[i] = (m_age[i] == 15);
        return {act, g, ix, act && (m_rem == 0), s};
    endfunction

    // Reference: urgency = (3 - prior) + age, highest wins, lowest index on ties.
    task automatic model_edge();
        int best;
        int bu;
        int u;
        int old_owner;
        bit arb;
        int nage [4];
        if (!rst_n) begin
            m_owner = -1;
            m_rem = 0;
            for (int i = 0; i < 4; i++) m_age[i] = 0;
            return;
        end
        best = -1;
        bu = -1;
        for (int i = 0; i < 4; i++) begin
            if (request[i] && !mask[i]) begin
                u = 3 - int'(prior[2*i +: 2]) + m_age[i];
                if (u > bu) begin
                    bu = u;
                    best = i;
                end
            end
        end
        old_owner = m_owner;
        for (int i = 0; i < 4; i++) begin
            if (request[i] && !mask[i] && i != old_owner)
                nage[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
            else
                nage[i] = m_age[i];
        end
        arb = 1'b0;
        if (m_owner < 0) begin
            arb = enable && (best >= 0);
        end else if (!request[m_owner]) begin
            m_owner = -1;
            m_rem = 0;
        end else if (beat) begin
            if (m_rem > 0) m_rem--;
            else if (enable && best >= 0) arb = 1'b1;
            else m_owner = -1;
        end
        if (arb) begin
            m_owner = best;
            m_rem = int'(burst_len[4*best +: 4]);
            nage[best] = 0;
        end
        for (int i = 0; i < 4; i++) m_age[i] = nage[i];
    endtask

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        request = '0;
        mask = '0;
        beat = 1'b0;
        enable = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        bit seen;

        tbl[0]  = mk(0, 1, 4'hF, 4'h0, 8'h00, 16'h2222, 0, 0, 4'b0000, 2'd0, 0, 4'h0);
        tbl[1]  = mk(1, 1, 4'hF, 4'h0, 8'h00, 16'h2222, 0, 1, 4'b0001, 2'd0, 0, 4'h0);
        tbl[2]  = mk(1, 1, 4'hF, 4'h0, 8'h00, 16'h2222, 1, 1, 4'b0001, 2'd0, 0, 4'h0);
        tbl[3]  = mk(1, 1, 4'hF, 4'h0, 8'h00, 16'h2222, 1, 1, 4'b0001, 2'd0, 1, 4'h0);
        tbl[4]  = mk(1, 1, 4'hF, 4'h0, 8'h00, 16'h2222, 1, 1, 4'b0010, 2'd1, 0, 4'h0);
        tbl[5]  = mk(0, 1, 4'h9, 4'h0, 8'h3F, 16'h2222, 0, 0, 4'b0000, 2'd0, 0, 4'h0);
        tbl[6]  = mk(1, 1, 4'h9, 4'h0, 8'h3F, 16'h2222, 0, 1, 4'b1000, 2'd3, 0, 4'h0);
        tbl[7]  = mk(1, 1, 4'h9, 4'h0, 8'h3F, 16'h2222, 1, 1, 4'b1000, 2'd3, 0, 4'h0);
        tbl[8]  = mk(1, 1, 4'h9, 4'h0, 8'h3F, 16'h2222, 1, 1, 4'b1000, 2'd3, 1, 4'h0);
        tbl[9]  = mk(1, 1, 4'h9, 4'h0, 8'h3F, 16'h2222, 1, 1, 4'b0001, 2'd0, 0, 4'h0);
        tbl[10] = mk(1, 1, 4'h8, 4'h0, 8'h3F, 16'h2222, 1, 0, 4'b0000, 2'd0, 0, 4'h0);
        tbl[11] = mk(1, 1, 4'h8, 4'h0, 8'h3F, 16'h2222, 0, 1, 4'b1000, 2'd3, 0, 4'h0);
        tbl[12] = mk(1, 0, 4'h8, 4'h0, 8'h3F, 16'h2222, 1, 1, 4'b1000, 2'd3, 0, 4'h0);
        tbl[13] = mk(1, 0, 4'h8, 4'h0, 8'h3F, 16'h2222, 1, 1, 4'b1000, 2'd3, 1, 4'h0);
        tbl[14] = mk(1, 0, 4'h8, 4'h0, 8'h3F, 16'h2222, 1, 0, 4'b0000, 2'd0, 0, 4'h0);
        tbl[15] = mk(1, 0, 4'h8, 4'h0, 8'h3F, 16'h2222, 1, 0, 4'b0000, 2'd0, 0, 4'h0);
        tbl[16] = mk(1, 1, 4'h1, 4'h1, 8'h3F, 16'h2222, 0, 0, 4'b0000, 2'd0, 0, 4'h0);
        tbl[17] = mk(1, 1, 4'h1, 4'h1, 8'h3F, 16'h2222, 0, 0, 4'b0000, 2'd0, 0, 4'h0);

        foreach (tbl[k]) begin
            rst_n = tbl[k].rst_n;
            enable = tbl[k].en;
            request = tbl[k].req;
            mask = tbl[k].msk;
            prior = tbl[k].pri;
            burst_len = tbl[k].bl;
            beat = tbl[k].bt;
            step();
            check($sformatf("tbl%0d", k), dut_vec(), tbl[k].exp);
        end

        // Aging: requester 0 (prior 3) must eventually beat requester 1 (prior 0).
        do_reset();
        prior = 8'hF3;
        burst_len = 16'h0000;
        request = 4'b0011;
        beat = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 20 && !seen; cyc++) begin
            step();
            if (grant[0]) seen = 1'b1;
        end
        check("aging_grant0", {11'd0, seen}, 12'd1);
        check("aging_no_sat", {8'd0, age_sat}, 12'd0);

        // Abort: drop the owner's request after three beats.
        do_reset();
        prior = 8'h00;
        burst_len = 16'h0700;
        request = 4'b0100;
        beat = 1'b0;
        step();
        check("abort_own", {8'd0, grant}, 12'h004);
        request = 4'b0110;
        beat = 1'b1;
        repeat (3) step();
        request = 4'b0010;
        step();
        check("abort_drop", {granted, 7'd0, grant}, 12'h000);
        beat = 1'b0;
        step();
        check("abort_next", {granted, 7'd0, grant}, 12'h802);

        // Mid-burst reset, then restart with cleared ages.
        do_reset();
        request = 4'b0100;
        burst_len = 16'h0700;
        step();
        beat = 1'b1;
        request = 4'b1101;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        check("mid_reset", dut_vec(), 12'h000);
        rst_n = 1'b1;
        beat = 1'b0;
        step();
        check("post_reset", {granted, 7'd0, grant}, 12'h801);

        // Age saturation of a waiting requester during a long held burst.
        do_reset();
        burst_len = 16'hFFFF;
        prior = 8'h00;
        request = 4'b0001;
        step();
        request = 4'b0011;
        beat = 1'b0;
        repeat (14) step();
        check("sat_before", {8'd0, age_sat}, 12'h000);
        step();
        check("sat_after", {8'd0, age_sat}, 12'h002);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            enable = ($urandom_range(0, 9) != 0);
            request = 4'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            prior = 8'($urandom);
            burst_len = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                    : (16'($urandom) & 16'h3333);
            beat = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
